// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, IR field layout, instruction classes,
// branch FSM states and the DE/EX latch layout.
package decode_pkg;

    localparam int DW  = 16;
    localparam int PCW = 16;
    localparam int RIW = 4;

    localparam int OPC_LO = 24;
    localparam int DST_LO = 20;
    localparam int S1_LO  = 16;
    localparam int S2_LO  = 0;
    localparam int IMM_LO = 0;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_ADDI = 8'h05;
    localparam logic [7:0] OP_MOVI = 8'h06;
    localparam logic [7:0] OP_ST   = 8'h07;
    localparam logic [7:0] OP_BR   = 8'h10;
    localparam logic [7:0] OP_BRZ  = 8'h11;
    localparam logic [7:0] OP_NOP  = 8'hFF;

    typedef struct packed {
        logic uses_src1;
        logic uses_src2;
        logic writes_dest;
        logic is_branch;
    } inst_class_t;

    typedef enum logic {IDLE = 1'b0, BR_WAIT = 1'b1} br_state_t;

    typedef struct packed {
        logic            bubble;
        logic [PCW-1:0]  pc;
        logic [7:0]      opcode;
        logic [RIW-1:0]  dest;
        logic            writes_dest;
        logic [DW-1:0]   src1;
        logic [DW-1:0]   src2;
        logic [DW-1:0]   imm;
    } de_ex_t;

    localparam de_ex_t DE_EX_BUBBLE = '{bubble: 1'b1, pc: '0, opcode: OP_NOP, dest: '0,
                                        writes_dest: 1'b0, src1: '0, src2: '0, imm: '0};

    function automatic inst_class_t class_of(input logic [7:0] op);
        inst_class_t c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: c = 4'b1110;
            OP_ADDI:                       c = 4'b1010;
            OP_MOVI:                       c = 4'b0010;
            OP_ST:                         c = 4'b1100;
            OP_BR:                         c = 4'b0001;
            OP_BRZ:                        c = 4'b1001;
            default:                       c = 4'b0000;
        endcase
        return c;
    endfunction

    // Anything outside the map (including OP_NOP) never issues.
    function automatic logic is_known(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
            OP_MOVI, OP_ST, OP_BR, OP_BRZ: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register outstanding-writer counters with hazard queries and a sticky
// underflow flag for writebacks that arrive with no writer outstanding.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    parameter  int CNT_W    = 2,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             gclk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             dec_en,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic [IDX_W-1:0] src1_idx,
    input  logic [IDX_W-1:0] src2_idx,
    input  logic [IDX_W-1:0] dest_idx,
    output logic             src1_busy,
    output logic             src2_busy,
    output logic             src1_one,
    output logic             src2_one,
    output logic             dest_full,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_hit, dec_hit, uf_hit;

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        uf_hit  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_hit[r] = inc_en && (inc_idx == IDX_W'(r));
            dec_hit[r] = dec_en && (dec_idx == IDX_W'(r));
            uf_hit[r]  = dec_hit[r] && !inc_hit[r] && (cnt[r] == '0);
        end
    end

    // A matching inc/dec pair cancels; a lone dec at zero saturates and flags.
    always_ff @(posedge gclk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_hit[r] && !dec_hit[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec_hit[r] && !inc_hit[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
            if (|uf_hit) underflow <= 1'b1;
        end
    end

    assign src1_busy = (cnt[src1_idx] != '0);
    assign src2_busy = (cnt[src2_idx] != '0);
    assign src1_one  = (cnt[src1_idx] == CNT_ONE);
    assign src2_one  = (cnt[src2_idx] == CNT_ONE);
    assign dest_full = (cnt[dest_idx] == CNT_MAX);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register file, scoreboard-based stall generation, branch-wait FSM
// and the DE/EX latch. Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data.
module decode_stage
    import decode_pkg::*;
#(
    parameter  int NUM_REGS     = 16,
    parameter  int DATA_WIDTH   = 16,
    parameter  int SB_CNT_WIDTH = 2,
    localparam int IDX_W        = $clog2(NUM_REGS)
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic [15:0]           I_PC,
    input  logic [31:0]           I_IR,
    input  logic                  I_FetchStall,
    input  logic                  I_BranchAddrSelect,
    input  logic                  I_WriteBackEnable,
    input  logic [IDX_W-1:0]      I_WriteBackRegIdx,
    input  logic [DATA_WIDTH-1:0] I_WriteBackData,
    output logic                  O_DepStallSignal,
    output logic                  O_BranchStallSignal,
    output logic                  O_DecodeStall,
    output logic [15:0]           O_PC,
    output logic [7:0]            O_Opcode,
    output logic [3:0]            O_DestRegIdx,
    output logic                  O_WritesDest,
    output logic [DATA_WIDTH-1:0] O_Src1Value,
    output logic [DATA_WIDTH-1:0] O_Src2Value,
    output logic [DATA_WIDTH-1:0] O_Imm
);

`ifdef DECODE_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    logic [7:0]            opcode;
    logic [IDX_W-1:0]      dest_idx, src1_idx, src2_idx;
    inst_class_t           cls;
    br_state_t             state, state_nxt;
    logic [DATA_WIDTH-1:0] rf [NUM_REGS];
    logic [DATA_WIDTH-1:0] src1_val, src2_val;
    logic                  valid, hazard, issue;
    logic                  src1_busy, src2_busy, src1_one, src2_one, dest_full;
    logic                  byp1, byp2, src1_haz, src2_haz;
    logic                  sb_underflow;
    logic                  unused_ok;
    de_ex_t                de_ex, de_ex_nxt;

    assign opcode   = I_IR[OPC_LO +: 8];
    assign dest_idx = IDX_W'(I_IR[DST_LO +: RIW]);
    assign src1_idx = IDX_W'(I_IR[S1_LO +: RIW]);
    assign src2_idx = IDX_W'(I_IR[S2_LO +: RIW]);
    assign cls      = class_of(opcode);

    // BR_WAIT swallows every input as a bubble, so valid already masks it.
    assign valid = !I_FetchStall && (state == IDLE) && is_known(opcode);

    // The last outstanding writer retiring this cycle can feed the reader directly.
    assign byp1 = WB_BYPASS && I_WriteBackEnable && (I_WriteBackRegIdx == src1_idx) && src1_one;
    assign byp2 = WB_BYPASS && I_WriteBackEnable && (I_WriteBackRegIdx == src2_idx) && src2_one;

    assign src1_haz = cls.uses_src1 && src1_busy && !byp1;
    assign src2_haz = cls.uses_src2 && src2_busy && !byp2;
    assign hazard   = valid && (src1_haz || src2_haz || (cls.writes_dest && dest_full));
    assign issue    = valid && !hazard;

    assign O_DepStallSignal = hazard;

    decode_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (SB_CNT_WIDTH)
    ) u_sb (
        .gclk      (I_CLOCK),
        .rst       (I_RESET),
        .inc_en    (issue && cls.writes_dest),
        .inc_idx   (dest_idx),
        .dec_en    (I_WriteBackEnable),
        .dec_idx   (I_WriteBackRegIdx),
        .src1_idx  (src1_idx),
        .src2_idx  (src2_idx),
        .dest_idx  (dest_idx),
        .src1_busy (src1_busy),
        .src2_busy (src2_busy),
        .src1_one  (src1_one),
        .src2_one  (src2_one),
        .dest_full (dest_full),
        .underflow (sb_underflow)
    );

    // Underflow is a debug-visible sticky flag; nothing in the datapath consumes it.
    assign unused_ok = sb_underflow;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
        end else if (I_WriteBackEnable) begin
            rf[I_WriteBackRegIdx] <= I_WriteBackData;
        end
    end

    always_comb begin
        src1_val = '0;
        src2_val = '0;
        if (cls.uses_src1) src1_val = byp1 ? I_WriteBackData : rf[src1_idx];
        if (cls.uses_src2) src2_val = byp2 ? I_WriteBackData : rf[src2_idx];
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue && cls.is_branch) state_nxt = BR_WAIT;
            BR_WAIT: if (I_BranchAddrSelect)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign O_BranchStallSignal = (state == BR_WAIT);

    always_comb begin
        de_ex_nxt = DE_EX_BUBBLE;
        if (issue) begin
            de_ex_nxt.bubble      = 1'b0;
            de_ex_nxt.pc          = I_PC;
            de_ex_nxt.opcode      = opcode;
            de_ex_nxt.dest        = I_IR[DST_LO +: RIW];
            de_ex_nxt.writes_dest = cls.writes_dest;
            de_ex_nxt.src1        = src1_val;
            de_ex_nxt.src2        = src2_val;
            de_ex_nxt.imm         = I_IR[IMM_LO +: DW];
        end
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) de_ex <= DE_EX_BUBBLE;
        else         de_ex <= de_ex_nxt;
    end

    assign O_DecodeStall = de_ex.bubble;
    assign O_PC          = de_ex.pc;
    assign O_Opcode      = de_ex.opcode;
    assign O_DestRegIdx  = de_ex.dest;
    assign O_WritesDest  = de_ex.writes_dest;
    assign O_Src1Value   = de_ex.src1;
    assign O_Src2Value   = de_ex.src2;
    assign O_Imm         = de_ex.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, RAW/WAW stalls, branch wait, inc/dec collision,
// mid-operation reset. Expectations follow DECODE_WB_BYPASS_EN when it is defined.
module tb_decode_stage;
    import decode_pkg::*;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET;
    logic [15:0] I_PC;
    logic [31:0] I_IR;
    logic        I_FetchStall, I_BranchAddrSelect, I_WriteBackEnable;
    logic [3:0]  I_WriteBackRegIdx;
    logic [15:0] I_WriteBackData;
    logic        O_DepStallSignal, O_BranchStallSignal, O_DecodeStall, O_WritesDest;
    logic [15:0] O_PC, O_Src1Value, O_Src2Value, O_Imm;
    logic [7:0]  O_Opcode;
    logic [3:0]  O_DestRegIdx;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_PC(I_PC), .I_IR(I_IR),
        .I_FetchStall(I_FetchStall), .I_BranchAddrSelect(I_BranchAddrSelect),
        .I_WriteBackEnable(I_WriteBackEnable), .I_WriteBackRegIdx(I_WriteBackRegIdx),
        .I_WriteBackData(I_WriteBackData), .O_DepStallSignal(O_DepStallSignal),
        .O_BranchStallSignal(O_BranchStallSignal), .O_DecodeStall(O_DecodeStall),
        .O_PC(O_PC), .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx),
        .O_WritesDest(O_WritesDest), .O_Src1Value(O_Src1Value),
        .O_Src2Value(O_Src2Value), .O_Imm(O_Imm)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    function automatic logic [31:0] mk_r(logic [7:0] op, logic [3:0] d, logic [3:0] s1, logic [3:0] s2);
        return {op, d, s1, 12'h000, s2};
    endfunction

    function automatic logic [31:0] mk_i(logic [7:0] op, logic [3:0] d, logic [3:0] s1, logic [15:0] imm);
        return {op, d, s1, imm};
    endfunction

    task automatic tick();
        @(posedge I_CLOCK);
        #1;
    endtask

    task automatic drive(logic [15:0] pc, logic [31:0] ir, logic fs);
        I_PC = pc; I_IR = ir; I_FetchStall = fs;
    endtask

    task automatic wb(logic [3:0] idx, logic [15:0] data);
        I_WriteBackEnable = 1'b1; I_WriteBackRegIdx = idx; I_WriteBackData = data;
    endtask

    task automatic wb_off();
        I_WriteBackEnable = 1'b0; I_WriteBackRegIdx = '0; I_WriteBackData = '0;
    endtask

    task automatic idle_in();
        drive(16'h0000, {OP_NOP, 24'h0}, 1'b1);
        I_BranchAddrSelect = 1'b0;
    endtask

    task automatic test_reset();
        I_RESET = 1'b1; idle_in(); wb(4'd1, 16'h0099);
        tick(); tick();
        I_RESET = 1'b0; wb_off();
        total++; if (O_DecodeStall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%0h exp=1", O_DecodeStall); end
        total++; if (O_WritesDest !== 1'b0) begin bad++; $display("FAIL rst_wd got=%0h exp=0", O_WritesDest); end
        total++; if (O_Opcode !== 8'hFF) begin bad++; $display("FAIL rst_opc got=%0h exp=ff", O_Opcode); end
        total++; if ({O_PC, O_DestRegIdx, O_Src1Value, O_Src2Value, O_Imm} !== 68'h0) begin bad++; $display("FAIL rst_fields got=%0h exp=0", {O_PC, O_DestRegIdx, O_Src1Value, O_Src2Value, O_Imm}); end
        total++; if (O_BranchStallSignal !== 1'b0) begin bad++; $display("FAIL rst_brstall got=%0h exp=0", O_BranchStallSignal); end
        for (int i = 0; i < 4; i++) begin
            if (i[0]) drive(16'h0004, {OP_NOP, 24'h0}, 1'b0);
            else      drive(16'h0008, mk_r(OP_ADD, 4'd3, 4'd1, 4'd2), 1'b1);
            #1;
            total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL nop_dep got=%0h exp=0", O_DepStallSignal); end
            tick();
            total++; if (O_DecodeStall !== 1'b1 || O_BranchStallSignal !== 1'b0) begin bad++; $display("FAIL nop_bubble got=%0h%0h exp=10", O_DecodeStall, O_BranchStallSignal); end
        end
        for (int r = 0; r < 16; r++) begin
            total++; if (dut.u_sb.cnt[r] !== 2'd0) begin bad++; $display("FAIL nop_cnt r%0d got=%0d exp=0", r, dut.u_sb.cnt[r]); end
        end
        // writeback presented during reset must not have landed in r1
        drive(16'h0020, mk_r(OP_ST, 4'd0, 4'd1, 4'd2), 1'b0);
        tick();
        total++; if (O_DecodeStall !== 1'b0 || O_Opcode !== OP_ST || O_PC !== 16'h0020) begin bad++; $display("FAIL st_issue got=%0h/%0h/%0h exp=0/07/0020", O_DecodeStall, O_Opcode, O_PC); end
        total++; if (O_Src1Value !== 16'h0000) begin bad++; $display("FAIL rst_wb_discard got=%0h exp=0", O_Src1Value); end
        idle_in();
    endtask

    task automatic test_load();
        wb(4'd1, 16'h0005); tick();
        wb(4'd2, 16'h0003); tick();
        wb_off();
        total++; if (dut.sb_underflow !== 1'b1) begin bad++; $display("FAIL underflow_set got=%0h exp=1", dut.sb_underflow); end
        total++; if (dut.u_sb.cnt[1] !== 2'd0) begin bad++; $display("FAIL underflow_sat got=%0d exp=0", dut.u_sb.cnt[1]); end
    endtask

    task automatic test_raw();
        drive(16'h0100, mk_r(OP_ADD, 4'd3, 4'd1, 4'd2), 1'b0); #1;
        total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL raw_add_dep got=%0h exp=0", O_DepStallSignal); end
        tick();
        total++; if (O_DecodeStall !== 1'b0 || O_Opcode !== OP_ADD || O_DestRegIdx !== 4'd3 || O_WritesDest !== 1'b1) begin bad++; $display("FAIL raw_add_latch got=%0h/%0h/%0h/%0h exp=0/01/3/1", O_DecodeStall, O_Opcode, O_DestRegIdx, O_WritesDest); end
        total++; if (O_Src1Value !== 16'h0005 || O_Src2Value !== 16'h0003 || O_PC !== 16'h0100) begin bad++; $display("FAIL raw_add_vals got=%0h/%0h/%0h exp=5/3/100", O_Src1Value, O_Src2Value, O_PC); end
        drive(16'h0104, mk_r(OP_SUB, 4'd4, 4'd3, 4'd1), 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (O_DepStallSignal !== 1'b1) begin bad++; $display("FAIL raw_dep c%0d got=%0h exp=1", i, O_DepStallSignal); end
            tick();
            total++; if (O_DecodeStall !== 1'b1 || O_WritesDest !== 1'b0) begin bad++; $display("FAIL raw_bubble c%0d got=%0h%0h exp=10", i, O_DecodeStall, O_WritesDest); end
        end
        wb(4'd3, 16'h0042); #1;
`ifdef DECODE_WB_BYPASS_EN
        total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL raw_byp_dep got=%0h exp=0", O_DepStallSignal); end
        tick(); wb_off();
`else
        total++; if (O_DepStallSignal !== 1'b1) begin bad++; $display("FAIL raw_wb_dep got=%0h exp=1", O_DepStallSignal); end
        tick(); wb_off();
        total++; if (O_DecodeStall !== 1'b1) begin bad++; $display("FAIL raw_wb_bubble got=%0h exp=1", O_DecodeStall); end
        #1;
        total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL raw_post_dep got=%0h exp=0", O_DepStallSignal); end
        tick();
`endif
        total++; if (O_DecodeStall !== 1'b0 || O_Opcode !== OP_SUB || O_Src1Value !== 16'h0042 || O_Src2Value !== 16'h0005) begin bad++; $display("FAIL raw_sub got=%0h/%0h/%0h/%0h exp=0/02/42/5", O_DecodeStall, O_Opcode, O_Src1Value, O_Src2Value); end
        idle_in();
        total++; if (dut.u_sb.cnt[3] !== 2'd0 || dut.u_sb.cnt[4] !== 2'd1) begin bad++; $display("FAIL raw_cnt got=%0d/%0d exp=0/1", dut.u_sb.cnt[3], dut.u_sb.cnt[4]); end
        wb(4'd4, 16'h003D); tick(); wb_off();
    endtask

    task automatic test_waw();
        for (int i = 0; i < 3; i++) begin
            drive(16'h0200 + 16'(4 * i), mk_i(OP_ADDI, 4'd5, 4'd1, 16'h0001), 1'b0); #1;
            total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL waw_dep w%0d got=%0h exp=0", i, O_DepStallSignal); end
            tick();
            total++; if (O_DecodeStall !== 1'b0 || O_DestRegIdx !== 4'd5) begin bad++; $display("FAIL waw_issue w%0d got=%0h/%0h exp=0/5", i, O_DecodeStall, O_DestRegIdx); end
        end
        total++; if (dut.u_sb.cnt[5] !== 2'd3) begin bad++; $display("FAIL waw_cnt_max got=%0d exp=3", dut.u_sb.cnt[5]); end
        drive(16'h0210, mk_i(OP_ADDI, 4'd5, 4'd1, 16'h0001), 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (O_DepStallSignal !== 1'b1) begin bad++; $display("FAIL waw_hold c%0d got=%0h exp=1", i, O_DepStallSignal); end
            tick();
            total++; if (O_DecodeStall !== 1'b1) begin bad++; $display("FAIL waw_bubble c%0d got=%0h exp=1", i, O_DecodeStall); end
        end
        wb(4'd5, 16'h0006); #1;
        total++; if (O_DepStallSignal !== 1'b1) begin bad++; $display("FAIL waw_wb_cycle got=%0h exp=1", O_DepStallSignal); end
        tick(); wb_off(); #1;
        total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL waw_release got=%0h exp=0", O_DepStallSignal); end
        tick();
        total++; if (O_DecodeStall !== 1'b0 || O_Imm !== 16'h0001 || O_Src1Value !== 16'h0005 || O_PC !== 16'h0210) begin bad++; $display("FAIL waw_4th got=%0h/%0h/%0h/%0h exp=0/1/5/210", O_DecodeStall, O_Imm, O_Src1Value, O_PC); end
        idle_in();
        for (int i = 0; i < 3; i++) begin wb(4'd5, 16'h0006); tick(); end
        wb_off();
        total++; if (dut.u_sb.cnt[5] !== 2'd0) begin bad++; $display("FAIL waw_drain got=%0d exp=0", dut.u_sb.cnt[5]); end
    endtask

    task automatic test_branch();
        drive(16'h000C, mk_i(OP_ADDI, 4'd5, 4'd1, 16'h0002), 1'b0); tick();
        drive(16'h0010, mk_i(OP_BRZ, 4'd0, 4'd5, 16'h0100), 1'b0); #1;
        total++; if (O_DepStallSignal !== 1'b1) begin bad++; $display("FAIL br_blocked_dep got=%0h exp=1", O_DepStallSignal); end
        tick();
        total++; if (O_BranchStallSignal !== 1'b0 || O_DecodeStall !== 1'b1) begin bad++; $display("FAIL br_blocked got=%0h%0h exp=01", O_BranchStallSignal, O_DecodeStall); end
        I_FetchStall = 1'b1; wb(4'd5, 16'h0007); tick(); wb_off();
        total++; if (O_BranchStallSignal !== 1'b0) begin bad++; $display("FAIL br_still_idle got=%0h exp=0", O_BranchStallSignal); end
        I_FetchStall = 1'b0; #1;
        total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL br_issue_dep got=%0h exp=0", O_DepStallSignal); end
        tick();
        total++; if (O_DecodeStall !== 1'b0 || O_Opcode !== OP_BRZ || O_PC !== 16'h0010 || O_Src1Value !== 16'h0007) begin bad++; $display("FAIL br_issue got=%0h/%0h/%0h/%0h exp=0/11/10/7", O_DecodeStall, O_Opcode, O_PC, O_Src1Value); end
        for (int i = 1; i <= 4; i++) begin
            total++; if (O_BranchStallSignal !== 1'b1) begin bad++; $display("FAIL br_wait c%0d got=%0h exp=1", i, O_BranchStallSignal); end
            drive(16'h0010 + 16'(4 * i), mk_r(OP_ADD, 4'd8, 4'd1, 4'd2), 1'b0);
            I_BranchAddrSelect = (i == 4);
            if (i == 2) wb(4'd6, 16'h1234);
            #1;
            total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL br_wait_dep c%0d got=%0h exp=0", i, O_DepStallSignal); end
            tick(); wb_off();
            total++; if (O_DecodeStall !== 1'b1 || O_WritesDest !== 1'b0) begin bad++; $display("FAIL br_wait_bubble c%0d got=%0h%0h exp=10", i, O_DecodeStall, O_WritesDest); end
        end
        I_BranchAddrSelect = 1'b0;
        total++; if (O_BranchStallSignal !== 1'b0) begin bad++; $display("FAIL br_release got=%0h exp=0", O_BranchStallSignal); end
        total++; if (dut.u_sb.cnt[8] !== 2'd0) begin bad++; $display("FAIL br_no_inc got=%0d exp=0", dut.u_sb.cnt[8]); end
        drive(16'h0030, mk_r(OP_ST, 4'd0, 4'd6, 4'd1), 1'b0); tick();
        total++; if (O_DecodeStall !== 1'b0 || O_Src1Value !== 16'h1234 || O_Src2Value !== 16'h0005) begin bad++; $display("FAIL br_wb_kept got=%0h/%0h/%0h exp=0/1234/5", O_DecodeStall, O_Src1Value, O_Src2Value); end
        idle_in(); I_BranchAddrSelect = 1'b1; tick(); I_BranchAddrSelect = 1'b0;
        total++; if (O_BranchStallSignal !== 1'b0) begin bad++; $display("FAIL br_idle_pulse got=%0h exp=0", O_BranchStallSignal); end
    endtask

    task automatic test_simul();
        drive(16'h0300, mk_i(OP_ADDI, 4'd7, 4'd1, 16'h0002), 1'b0); tick();
        total++; if (dut.u_sb.cnt[7] !== 2'd1) begin bad++; $display("FAIL sim_pre got=%0d exp=1", dut.u_sb.cnt[7]); end
        drive(16'h0304, mk_i(OP_ADDI, 4'd7, 4'd1, 16'h0003), 1'b0); wb(4'd7, 16'h0077); #1;
        total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL sim_dep got=%0h exp=0", O_DepStallSignal); end
        tick(); wb_off();
        total++; if (O_DecodeStall !== 1'b0 || dut.u_sb.cnt[7] !== 2'd1) begin bad++; $display("FAIL sim_cnt got=%0h/%0d exp=0/1", O_DecodeStall, dut.u_sb.cnt[7]); end
        drive(16'h0308, mk_r(OP_ST, 4'd0, 4'd7, 4'd1), 1'b0); #1;
        total++; if (O_DepStallSignal !== 1'b1) begin bad++; $display("FAIL sim_reader_dep got=%0h exp=1", O_DepStallSignal); end
        tick();
        I_FetchStall = 1'b1; wb(4'd7, 16'h0078); tick(); wb_off();
        total++; if (dut.u_sb.cnt[7] !== 2'd0) begin bad++; $display("FAIL sim_retired got=%0d exp=0", dut.u_sb.cnt[7]); end
        I_FetchStall = 1'b0; #1;
        total++; if (O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL sim_reader_go got=%0h exp=0", O_DepStallSignal); end
        tick();
        total++; if (O_DecodeStall !== 1'b0 || O_Src1Value !== 16'h0078) begin bad++; $display("FAIL sim_reader_val got=%0h/%0h exp=0/78", O_DecodeStall, O_Src1Value); end
        idle_in();
    endtask

    task automatic test_reset_mid();
        drive(16'h0400, mk_i(OP_ADDI, 4'd9, 4'd1, 16'h0003), 1'b0); tick();
        drive(16'h0050, mk_i(OP_BR, 4'd0, 4'd0, 16'h0040), 1'b0); tick();
        total++; if (O_BranchStallSignal !== 1'b1 || dut.u_sb.cnt[9] !== 2'd1) begin bad++; $display("FAIL mid_pre got=%0h/%0d exp=1/1", O_BranchStallSignal, dut.u_sb.cnt[9]); end
        I_RESET = 1'b1; wb(4'd1, 16'hBEEF); drive(16'h0054, mk_r(OP_ADD, 4'd10, 4'd1, 4'd2), 1'b0);
        tick();
        I_RESET = 1'b0; wb_off(); idle_in(); #1;
        total++; if (O_BranchStallSignal !== 1'b0 || O_DecodeStall !== 1'b1 || O_Opcode !== 8'hFF) begin bad++; $display("FAIL mid_state got=%0h/%0h/%0h exp=0/1/ff", O_BranchStallSignal, O_DecodeStall, O_Opcode); end
        total++; if (O_PC !== 16'h0 || O_Src1Value !== 16'h0 || O_WritesDest !== 1'b0 || O_DepStallSignal !== 1'b0) begin bad++; $display("FAIL mid_fields got=%0h/%0h/%0h/%0h exp=0/0/0/0", O_PC, O_Src1Value, O_WritesDest, O_DepStallSignal); end
        total++; if (dut.u_sb.cnt[9] !== 2'd0 || dut.sb_underflow !== 1'b0) begin bad++; $display("FAIL mid_sb got=%0d/%0h exp=0/0", dut.u_sb.cnt[9], dut.sb_underflow); end
        drive(16'h0060, mk_r(OP_ST, 4'd0, 4'd1, 4'd2), 1'b0); tick();
        total++; if (O_DecodeStall !== 1'b0 || O_Src1Value !== 16'h0 || O_Src2Value !== 16'h0) begin bad++; $display("FAIL mid_rf got=%0h/%0h/%0h exp=0/0/0", O_DecodeStall, O_Src1Value, O_Src2Value); end
        idle_in();
    endtask

    initial begin
        I_RESET = 1'b1;
        idle_in();
        wb_off();
        test_reset();
        test_load();
        test_raw();
        test_waw();
        test_branch();
        test_simul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
